memory_stage: RTL and testbench

//  MEM stage directly downstream of the execute stage. Consumes the ALU result and the

---
 rtl/memory_stage_pkg.sv | 34 +++
 rtl/memory_stage_spu.sv | 53 +++++
 rtl/memory_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_memory_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared encodings and defaults for the MEM stage
package memory_stage_pkg;

  localparam logic [15:0] SP_INIT_DEFAULT     = 16'h07FF;
  localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'h0400;

  // Memory operation encodings as presented by the execute stage
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_INT   = 3'd7
  } mem_op_e;

  // Two-word sequencer states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } mem_state_e;

  // Stack pointer update requests
  typedef enum logic [2:0] {
    SP_HOLD = 3'd0,
    SP_INC1 = 3'd1,
    SP_INC2 = 3'd2,
    SP_DEC1 = 3'd3,
    SP_DEC2 = 3'd4
  } sp_op_e;

endpackage

// File: rtl/memory_stage_spu.sv
// rtl/memory_stage_spu.sv - stack pointer register with offset addresses and limit checks
import memory_stage_pkg::*;

module stack_pointer_unit #(
  parameter logic [15:0] SP_INIT     = SP_INIT_DEFAULT,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  sp_op_e      sp_op,
  output logic [15:0] sp,
  output logic [15:0] sp_p1,
  output logic [15:0] sp_p2,
  output logic [15:0] sp_m1,
  output logic        ovf0,
  output logic        ovf1,
  output logic        unf1,
  output logic        unf2
);

  logic [16:0] sum1;
  logic [16:0] sum2;

  // Pop addresses are computed one bit wider so the underflow compare never wraps
  assign sum1  = {1'b0, sp} + 17'd1;
  assign sum2  = {1'b0, sp} + 17'd2;
  assign sp_p1 = sum1[15:0];
  assign sp_p2 = sum2[15:0];
  assign sp_m1 = sp - 16'd1;

  // A push word at address SP (first word) or SP-1 (second word) must stay at or above the limit
  assign ovf0 = (sp < STACK_LIMIT);
  assign ovf1 = (sp_m1 < STACK_LIMIT);
  // A pop word at SP+1 or SP+2 must not read above the empty-stack top
  assign unf1 = (sum1 > {1'b0, SP_INIT});
  assign unf2 = (sum2 > {1'b0, SP_INIT});

  // SP register: two-word ops move it by two only once the second word succeeds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_INIT;
    end else begin
      case (sp_op)
        SP_INC1: sp <= sp_p1;
        SP_INC2: sp <= sp_p2;
        SP_DEC1: sp <= sp_m1;
        SP_DEC2: sp <= sp - 16'd2;
        default: sp <= sp;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: stack ops, two-word call/return sequencing, MEM/WB registers
import memory_stage_pkg::*;

module memory_stage #(
  parameter logic [15:0] SP_INIT     = SP_INIT_DEFAULT,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  mem_op,
  input  logic        ex_rti,
  input  logic [15:0] ex_result,
  input  logic [15:0] ex_addr,
  input  logic [15:0] store_data,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        ccr_restore,
  output logic [2:0]  ccr_out,
  output logic        stack_exc
);

  mem_op_e    op;
  mem_state_e state;
  mem_state_e next_state;
  sp_op_e     sp_op;

  logic [15:0] sp;
  logic [15:0] sp_p1;
  logic [15:0] sp_p2;
  logic [15:0] sp_m1;
  logic        ovf0;
  logic        ovf1;
  logic        unf1;
  logic        unf2;

  // Second-word context captured when the first word is accepted
  logic        sec_push;
  logic        sec_rti;
  logic [15:0] ret_lo;
  logic [2:0]  shadow_ccr;

  logic        we_c;
  logic        n_wb_valid;
  logic [15:0] n_wb_data;
  logic        n_pc_load;
  logic [31:0] n_pc_target;
  logic        n_ccr_restore;
  logic        n_exc;
  logic [15:0] n_ret_lo;
  logic [2:0]  n_shadow;
  logic        n_sec_push;
  logic        n_sec_rti;

  assign op      = mem_op_e'(mem_op);
  assign ccr_out = shadow_ccr;
  // Keep the write strobe quiet while reset is held, whatever execute presents
  assign dmem_we = we_c & rst_n;

  stack_pointer_unit #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_spu (
    .clk   (clk),
    .rst_n (rst_n),
    .sp_op (sp_op),
    .sp    (sp),
    .sp_p1 (sp_p1),
    .sp_p2 (sp_p2),
    .sp_m1 (sp_m1),
    .ovf0  (ovf0),
    .ovf1  (ovf1),
    .unf1  (unf1),
    .unf2  (unf2)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, memory port muxing, stall and next values of the MEM/WB registers
  always_comb begin
    next_state    = state;
    stall         = 1'b0;
    dmem_addr     = ex_addr;
    dmem_wdata    = store_data;
    we_c          = 1'b0;
    sp_op         = SP_HOLD;
    n_wb_valid    = 1'b0;
    n_wb_data     = ex_result;
    n_pc_load     = 1'b0;
    n_pc_target   = pc_target;
    n_ccr_restore = 1'b0;
    n_exc         = 1'b0;
    n_ret_lo      = ret_lo;
    n_shadow      = shadow_ccr;
    n_sec_push    = sec_push;
    n_sec_rti     = sec_rti;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          case (op)
            OP_LOAD: begin
              n_wb_data  = dmem_rdata;
              n_wb_valid = 1'b1;
            end
            OP_STORE: begin
              we_c = 1'b1;
            end
            OP_PUSH: begin
              dmem_addr = sp;
              if (ovf0) begin
                n_exc = 1'b1;
              end else begin
                we_c  = 1'b1;
                sp_op = SP_DEC1;
              end
            end
            OP_POP: begin
              dmem_addr = sp_p1;
              if (unf1) begin
                n_exc = 1'b1;
              end else begin
                n_wb_data  = dmem_rdata;
                n_wb_valid = 1'b1;
                sp_op      = SP_INC1;
              end
            end
            OP_CALL, OP_INT: begin
              dmem_addr  = sp;
              dmem_wdata = pc_in[31:16];
              // A faulting first word never stalls, so execute is not held on a dead op
              if (ovf0) begin
                n_exc = 1'b1;
              end else begin
                we_c       = 1'b1;
                stall      = 1'b1;
                next_state = ST_SECOND;
                n_sec_push = 1'b1;
                if (op == OP_INT) begin
                  n_shadow = ccr_in;
                end
              end
            end
            OP_RET: begin
              dmem_addr = sp_p1;
              if (unf1) begin
                n_exc = 1'b1;
              end else begin
                n_ret_lo   = dmem_rdata;
                stall      = 1'b1;
                next_state = ST_SECOND;
                n_sec_push = 1'b0;
                n_sec_rti  = ex_rti;
              end
            end
            default: begin
              n_wb_valid = 1'b1;
            end
          endcase
        end
      end
      ST_SECOND: begin
        next_state = ST_IDLE;
        if (sec_push) begin
          dmem_addr  = sp_m1;
          dmem_wdata = pc_in[15:0];
          if (ovf1) begin
            n_exc = 1'b1;
          end else begin
            we_c  = 1'b1;
            sp_op = SP_DEC2;
          end
        end else begin
          dmem_addr = sp_p2;
          if (unf2) begin
            n_exc = 1'b1;
          end else begin
            sp_op         = SP_INC2;
            n_pc_load     = 1'b1;
            n_pc_target   = {dmem_rdata, ret_lo};
            n_ccr_restore = sec_rti;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // MEM/WB output registers and second-word context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= 16'h0000;
      pc_load     <= 1'b0;
      pc_target   <= 32'h0000_0000;
      ccr_restore <= 1'b0;
      stack_exc   <= 1'b0;
      ret_lo      <= 16'h0000;
      shadow_ccr  <= 3'b000;
      sec_push    <= 1'b0;
      sec_rti     <= 1'b0;
    end else begin
      wb_valid    <= n_wb_valid;
      wb_data     <= n_wb_data;
      pc_load     <= n_pc_load;
      pc_target   <= n_pc_target;
      ccr_restore <= n_ccr_restore;
      stack_exc   <= n_exc;
      ret_lo      <= n_ret_lo;
      shadow_ccr  <= n_shadow;
      sec_push    <= n_sec_push;
      sec_rti     <= n_sec_rti;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;

  localparam int SP_INIT     = 'h07FF;
  localparam int STACK_LIMIT = 'h0400;

  typedef struct {
    logic [2:0]  op;
    logic        rti;
    logic [15:0] res;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] pc;
    logic [2:0]  ccr;
  } in_t;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        pcl;
    logic [31:0] tgt;
    logic        ccrr;
    logic [2:0]  ccro;
    logic        exc;
    logic [15:0] sp;
    logic        stall;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  mem_op;
  logic        ex_rti;
  logic [15:0] ex_result;
  logic [15:0] ex_addr;
  logic [15:0] store_data;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic [15:0] dmem_rdata;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        ccr_restore;
  logic [2:0]  ccr_out;
  logic        stack_exc;

  logic [15:0] mem [0:65535];

  logic [15:0] ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  logic [15:0] m_sp;
  logic [2:0]  m_ccr;

  int n_cmp;
  int n_fail;

  memory_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .mem_op      (mem_op),
    .ex_rti      (ex_rti),
    .ex_result   (ex_result),
    .ex_addr     (ex_addr),
    .store_data  (store_data),
    .pc_in       (pc_in),
    .ccr_in      (ccr_in),
    .dmem_rdata  (dmem_rdata),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_we     (dmem_we),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .ccr_restore (ccr_restore),
    .ccr_out     (ccr_out),
    .stack_exc   (stack_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: async read, write on rising edge
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
  end
  assign dmem_rdata = mem[dmem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void wr_ref(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endfunction

  // Op-level reference: each op applied atomically to a stack pointer and memory image
  function automatic out_t model(input in_t x);
    out_t e;
    int   s;
    s = int'(m_sp);
    e = '{default: '0};
    case (x.op)
      3'd1: begin e.valid = 1'b1; e.data = ref_mem[x.addr]; end
      3'd2: wr_ref(x.addr, x.data);
      3'd3: begin
        if (s < STACK_LIMIT) e.exc = 1'b1;
        else begin wr_ref(m_sp, x.data); m_sp = m_sp - 16'd1; end
      end
      3'd4: begin
        if (s + 1 > SP_INIT) e.exc = 1'b1;
        else begin e.valid = 1'b1; e.data = ref_mem[m_sp + 16'd1]; m_sp = m_sp + 16'd1; end
      end
      3'd5, 3'd7: begin
        if (s < STACK_LIMIT) e.exc = 1'b1;
        else begin
          e.stall = 1'b1;
          wr_ref(m_sp, x.pc[31:16]);
          if (x.op == 3'd7) m_ccr = x.ccr;
          if (s - 1 < STACK_LIMIT) e.exc = 1'b1;
          else begin wr_ref(m_sp - 16'd1, x.pc[15:0]); m_sp = m_sp - 16'd2; end
        end
      end
      3'd6: begin
        if (s + 1 > SP_INIT) e.exc = 1'b1;
        else begin
          e.stall = 1'b1;
          if (s + 2 > SP_INIT) e.exc = 1'b1;
          else begin
            e.pcl  = 1'b1;
            e.tgt  = {ref_mem[m_sp + 16'd2], ref_mem[m_sp + 16'd1]};
            e.ccrr = x.rti;
            m_sp   = m_sp + 16'd2;
          end
        end
      end
      default: begin e.valid = 1'b1; e.data = x.res; end
    endcase
    e.sp   = m_sp;
    e.ccro = m_ccr;
    return e;
  endfunction

  task automatic run_op(input in_t x, output out_t a);
    @(negedge clk);
    ex_valid   = 1'b1;
    mem_op     = x.op;
    ex_rti     = x.rti;
    ex_result  = x.res;
    ex_addr    = x.addr;
    store_data = x.data;
    pc_in      = x.pc;
    ccr_in     = x.ccr;
    #1;
    a.stall = stall;
    @(posedge clk);
    #1;
    if (a.stall) begin
      chk("second_word_stall", stall, 1'b0);
      @(posedge clk);
      #1;
    end
    a.valid = wb_valid;
    a.data  = wb_data;
    a.pcl   = pc_load;
    a.tgt   = pc_target;
    a.ccrr  = ccr_restore;
    a.ccro  = ccr_out;
    a.exc   = stack_exc;
    a.sp    = dut.u_spu.sp;
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".stall"}, a.stall, e.stall);
    chk({tag, ".wb_valid"}, a.valid, e.valid);
    if (e.valid) chk({tag, ".wb_data"}, a.data, e.data);
    chk({tag, ".pc_load"}, a.pcl, e.pcl);
    if (e.pcl) chk({tag, ".pc_target"}, a.tgt, e.tgt);
    chk({tag, ".ccr_restore"}, a.ccrr, e.ccrr);
    chk({tag, ".ccr_out"}, a.ccro, e.ccro);
    chk({tag, ".stack_exc"}, a.exc, e.exc);
    chk({tag, ".sp"}, a.sp, e.sp);
  endtask

  task automatic step(input in_t x, input string tag);
    out_t e;
    out_t a;
    e = model(x);
    run_op(x, a);
    cmp_out(tag, a, e);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".wb_valid"}, wb_valid, 1'b0);
    chk({tag, ".pc_load"}, pc_load, 1'b0);
    chk({tag, ".ccr_restore"}, ccr_restore, 1'b0);
    chk({tag, ".stack_exc"}, stack_exc, 1'b0);
  endtask

  function automatic in_t mi(input logic [2:0] op, input logic rti, input logic [15:0] res,
                             input logic [15:0] addr, input logic [15:0] data,
                             input logic [31:0] pc, input logic [2:0] ccr);
    in_t x;
    x.op = op; x.rti = rti; x.res = res; x.addr = addr; x.data = data; x.pc = pc; x.ccr = ccr;
    return x;
  endfunction

  function automatic out_t mo(input logic valid, input logic [15:0] data, input logic pcl,
                              input logic [31:0] tgt, input logic ccrr, input logic [2:0] ccro,
                              input logic exc, input logic [15:0] sp, input logic stall_e);
    out_t o;
    o.valid = valid; o.data = data; o.pcl = pcl; o.tgt = tgt; o.ccrr = ccrr;
    o.ccro = ccro; o.exc = exc; o.sp = sp; o.stall = stall_e;
    return o;
  endfunction

  function automatic in_t rnd_in(input logic [2:0] op);
    return mi(op, 1'($urandom_range(0, 1)), 16'($urandom), 16'h0010 + 16'($urandom_range(0, 15)),
              16'($urandom), $urandom, 3'($urandom_range(0, 7)));
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;
    out_t a;
    out_t e;

    n_cmp = 0;
    n_fail = 0;
    m_sp = 16'(SP_INIT);
    m_ccr = 3'b000;
    for (int k = 0; k < 65536; k++) ref_wr[k] = 1'b0;

    rst_n = 1'b0; ex_valid = 1'b0; mem_op = 3'd0; ex_rti = 1'b0; ex_result = 16'h0;
    ex_addr = 16'h0; store_data = 16'h0; pc_in = 32'h0; ccr_in = 3'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.wb_valid", wb_valid, 1'b0);
    chk("reset.wb_data", wb_data, 16'h0);
    chk("reset.pc_load", pc_load, 1'b0);
    chk("reset.pc_target", pc_target, 32'h0);
    chk("reset.ccr_restore", ccr_restore, 1'b0);
    chk("reset.ccr_out", ccr_out, 3'b0);
    chk("reset.stack_exc", stack_exc, 1'b0);
    chk("reset.dmem_we", dmem_we, 1'b0);
    chk("reset.stall", stall, 1'b0);
    chk("reset.sp", dut.u_spu.sp, 16'h07FF);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: inputs and the values the stage must register
    v.i = mi(3'd3, 0, 16'h0, 16'h0, 16'hAAAA, 32'h0, 3'b0);        v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b000, 0, 16'h07FE, 0); tbl.push_back(v);
    v.i = mi(3'd4, 0, 16'h0, 16'h0, 16'h0, 32'h0, 3'b0);           v.o = mo(1, 16'hAAAA, 0, 32'h0, 0, 3'b000, 0, 16'h07FF, 0); tbl.push_back(v);
    v.i = mi(3'd2, 0, 16'h0, 16'h0010, 16'h1234, 32'h0, 3'b0);     v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b000, 0, 16'h07FF, 0); tbl.push_back(v);
    v.i = mi(3'd1, 0, 16'h0, 16'h0010, 16'h0, 32'h0, 3'b0);        v.o = mo(1, 16'h1234, 0, 32'h0, 0, 3'b000, 0, 16'h07FF, 0); tbl.push_back(v);
    v.i = mi(3'd0, 0, 16'h5A5A, 16'h0, 16'h0, 32'h0, 3'b0);        v.o = mo(1, 16'h5A5A, 0, 32'h0, 0, 3'b000, 0, 16'h07FF, 0); tbl.push_back(v);
    v.i = mi(3'd5, 0, 16'h0, 16'h0, 16'h0, 32'h0001_0020, 3'b0);   v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b000, 0, 16'h07FD, 1); tbl.push_back(v);
    v.i = mi(3'd6, 0, 16'h0, 16'h0, 16'h0, 32'h0, 3'b0);           v.o = mo(0, 16'h0, 1, 32'h0001_0020, 0, 3'b000, 0, 16'h07FF, 1); tbl.push_back(v);
    v.i = mi(3'd7, 0, 16'h0, 16'h0, 16'h0, 32'h0003_0044, 3'b101); v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b101, 0, 16'h07FD, 1); tbl.push_back(v);
    v.i = mi(3'd6, 1, 16'h0, 16'h0, 16'h0, 32'h0, 3'b0);           v.o = mo(0, 16'h0, 1, 32'h0003_0044, 1, 3'b101, 0, 16'h07FF, 1); tbl.push_back(v);
    v.i = mi(3'd4, 0, 16'h0, 16'h0, 16'h0, 32'h0, 3'b0);           v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b101, 1, 16'h07FF, 0); tbl.push_back(v);
    v.i = mi(3'd6, 1, 16'h0, 16'h0, 16'h0, 32'h0, 3'b0);           v.o = mo(0, 16'h0, 0, 32'h0, 0, 3'b101, 1, 16'h07FF, 0); tbl.push_back(v);

    foreach (tbl[k]) begin
      e = model(tbl[k].i);
      run_op(tbl[k].i, a);
      cmp_out($sformatf("vec%0d", k), a, tbl[k].o);
      if (k == 5) begin
        chk("call.mem07ff", mem[16'h07FF], 16'h0001);
        chk("call.mem07fe", mem[16'h07FE], 16'h0020);
      end
    end
    idle("pulse_end");

    // Preload the load/store window so random loads read known data
    for (int k = 0; k < 16; k++) step(mi(3'd2, 0, 16'h0, 16'h0010 + 16'(k), 16'($urandom), 32'h0, 3'b0), "preload");

    // Random mix of all ops against the op-level model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) idle("rnd_idle");
      else step(rnd_in(3'($urandom_range(0, 7))), $sformatf("rnd%0d", k));
    end

    // Drain to empty, then fill right down to the limit
    for (int g = 0; g < 1100 && m_sp != 16'(SP_INIT); g++) step(rnd_in(3'd4), "drain");
    for (int g = 0; g < 1100 && m_sp != 16'(STACK_LIMIT); g++) step(rnd_in(3'd3), "fill");
    step(rnd_in(3'd5), "call_at_limit");
    chk("call_at_limit.exc", stack_exc, 1'b1);
    chk("call_at_limit.sp", dut.u_spu.sp, 16'h0400);
    step(rnd_in(3'd3), "push_last");
    step(rnd_in(3'd3), "push_ovf");
    chk("push_ovf.exc", stack_exc, 1'b1);
    chk("push_ovf.sp", dut.u_spu.sp, 16'h03FF);
    step(rnd_in(3'd7), "int_ovf");
    step(rnd_in(3'd5), "call_ovf");
    idle("ovf_pulse_end");
    for (int g = 0; g < 1100 && m_sp != 16'(SP_INIT); g++) step(rnd_in(3'd4), "unwind");
    step(rnd_in(3'd4), "pop_unf");
    step(rnd_in(3'd3), "push_one");
    step(rnd_in(3'd6), "ret_unf2");

    // Reset asserted while the second word of a CALL is in flight
    for (int g = 0; g < 4 && m_sp != 16'(SP_INIT); g++) step(rnd_in(3'd4), "pre_rst");
    @(negedge clk);
    ex_valid = 1'b1; mem_op = 3'd5; pc_in = 32'h0007_0009;
    #1;
    chk("rst_call.stall", stall, 1'b1);
    wr_ref(m_sp, 16'h0007);
    @(posedge clk);
    #1;
    chk("rst_call.second_stall", stall, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_call.sp", dut.u_spu.sp, 16'h07FF);
    chk("rst_call.dmem_we", dmem_we, 1'b0);
    chk("rst_call.pc_load", pc_load, 1'b0);
    chk("rst_call.ccr_out", ccr_out, 3'b0);
    @(posedge clk);
    #1;
    chk("rst_call.pc_load_held", pc_load, 1'b0);
    chk("rst_call.sp_held", dut.u_spu.sp, 16'h07FF);
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    m_sp = 16'(SP_INIT);
    m_ccr = 3'b000;
    step(rnd_in(3'd3), "post_rst_push");
    step(rnd_in(3'd4), "post_rst_pop");
    idle("post_rst_idle");

    for (int k = 0; k < 65536; k++) begin
      if (ref_wr[k]) chk($sformatf("mem[%0h]", k), mem[k], ref_mem[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
